mdu_div_ctrl: RTL
=================

Name: mdu_div_ctrl

Overview:
- Multi-cycle sequencer for the M-extension divide/remainder ops (DIV, DIVU, REM, REMU) in the execute stage.
- Accepts a start pulse from EX and runs a radix-2 restoring divider, one step per cycle.
- Holds busy high so hazard control stalls the pipeline, then emits a one-cycle done with the result.
- Sits beside the ALU; EX muxes its result in when done is high.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new divide; sampled only in IDLE.
- div_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (codes in defines.vh).
- op1  input  WIDTH  dividend (rs1); captured on accepted start.
- op2  input  WIDTH  divisor (rs2); captured on accepted start.
- flush  input  1  abort the in-flight op (branch mispredict/trap).
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result is valid this cycle.
- result  output  WIDTH  quotient or remainder; holds its last value otherwise.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, internal quotient/remainder/iteration counter=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1 at cycle T: latch the following, then go to RUN at T+1.
  - div_op.
  - |op1| and |op2| for signed ops; raw values for unsigned ops.
  - quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
  - Special flags: div-by-zero (op2==0); signed overflow (op1=0x8000_0000, op2=0xFFFF_FFFF, signed op only).
- RUN: one restoring step per cycle.
  - rem = {rem, q_msb} − divisor.
  - Quotient bit = 1 if non-negative, else restore.
  - Counter counts WIDTH steps, cycles T+1..T+WIDTH; then go to FIX.
- FIX (T+WIDTH+1): apply sign correction and special-case overrides; go to DONE.
- DONE (T+WIDTH+2): done=1 and result valid; next state IDLE.
- Default latency: start at T, done at T+34 for WIDTH=32. busy is high T+1..T+34.
- start while busy: ignored; no queueing. start in the DONE cycle: ignored. EX re-issues after the stall drops.
- Special-case results (mandatory, RISC-V spec):
  - Divide by zero: DIV/DIVU = 0xFFFF_FFFF; REM/REMU = op1.
  - Signed overflow: DIV = 0x8000_0000; REM = 0.
  - These override the arithmetic in FIX regardless of iteration output.
- Sign rules: quotient negated if its latched sign=1. Remainder takes the dividend sign, so |rem| is negated if op1 was negative. Unsigned ops apply no correction.
- flush:
  - In RUN or FIX: go to IDLE next cycle, no done pulse, result unchanged.
  - Asserted in the DONE cycle: done still pulses; flush only kills future work.
  - flush with start in IDLE: start is ignored.
- Reset mid-operation: immediate return to IDLE; no done pulse.
- Arithmetic: remainder datapath is WIDTH+1 bits so the subtraction borrow is explicit. All negation is two's complement modulo 2^WIDTH.

Optional Feature:
- Macro: MDU_DIV_FASTPATH_EN.
- Defined: div-by-zero, signed-overflow, or op2==1 detected at start skip RUN. Path is IDLE→FIX→DONE, giving done at T+2. Results are identical to the slow path.
- Undefined: every op takes the full T+WIDTH+2 latency; special cases are resolved only in FIX.

Decomposition:
- defines.vh gains:
  - DIV_OP_DIV/DIVU/REM/REMU 2-bit codes.
  - MDU_ST_IDLE/RUN/FIX/DONE state encodings.
  - DIV_OVF_DIVIDEND (0x8000_0000) constant.
- One natural sub-module: div_step, purely combinational. Takes {rem, quo, divisor} and returns the next {rem, quo} for a single restoring iteration.
- The controller owns the FSM, counter and sign/special-case logic.

Test Plan:
- DIVU op1=100, op2=7, start at T → busy T+1..T+34, done at T+34, result=14; repeat as REMU → result=2.
- DIV op1=0xFFFF_FF9C (−100), op2=7 → result=0xFFFF_FFF2 (−14); REM same operands → 0xFFFF_FFFE (−2).
- DIV op1=5, op2=0 → 0xFFFF_FFFF; REMU op1=5, op2=0 → 5. Latency 34 without the macro, 2 with MDU_DIV_FASTPATH_EN.
- DIV op1=0x8000_0000, op2=0xFFFF_FFFF → 0x8000_0000; REM same operands → 0.
- Start DIVU 100/7, flush at T+10 → IDLE at T+11, no done, result unchanged. A second start at T+12 completes at T+46 with a correct value.
- Assert rst at T+20 during RUN → busy=0, done=0, result=0 immediately. A start held during busy is ignored and no extra done appears.

Source files
------------

// File: rtl/mdu_div_ctrl_pkg.sv
// Shared encodings for the divide sequencer: op codes, FSM states and helpers.
// Build option MDU_DIV_FASTPATH_EN (see mdu_div_ctrl.sv) does not affect this file.
package mdu_div_ctrl_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_RUN  = 2'd1,
    MDU_ST_FIX  = 2'd2,
    MDU_ST_DONE = 2'd3
  } mdu_state_e;

  // Bit 0 clear selects the signed flavour, bit 1 set selects remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_div_ctrl_div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore the partial remainder.
module mdu_div_ctrl_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The extra top bit of diff is the explicit borrow of the trial subtraction.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {2'b00, divisor};
    if (!diff[WIDTH+1]) begin
      rem_next = diff[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_div_ctrl.sv
// DIV/DIVU/REM/REMU sequencer: IDLE -> RUN (WIDTH steps) -> FIX -> DONE.
// Define MDU_DIV_FASTPATH_EN to send div-by-zero, signed overflow and op2==1 straight to FIX.
module mdu_div_ctrl
  import mdu_div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e state_reg, state_next;

  logic [1:0]       op_reg;
  logic [WIDTH-1:0] op1_reg, divisor_reg, quo_reg, result_reg;
  logic [WIDTH:0]   rem_reg;
  logic [CW-1:0]    cnt_reg;
  logic             q_neg_reg, r_neg_reg, div0_reg, ovf_reg;

  logic             start_accept, sgn, a_neg, b_neg, in_div0, in_ovf;
  logic [WIDTH-1:0] abs1, abs2, q_fix, r_fix, fix_value;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;

  assign start_accept = (state_reg == MDU_ST_IDLE) && start && !flush;
  assign sgn     = op_is_signed(div_op);
  assign a_neg   = sgn & op1[WIDTH-1];
  assign b_neg   = sgn & op2[WIDTH-1];
  assign abs1    = a_neg ? (~op1 + 1'b1) : op1;
  assign abs2    = b_neg ? (~op2 + 1'b1) : op2;
  assign in_div0 = (op2 == '0);
  assign in_ovf  = sgn && (op1 == MIN_VAL) && (op2 == '1);

  mdu_div_ctrl_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (divisor_reg),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= MDU_ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MDU_ST_IDLE: if (start_accept) begin
`ifdef MDU_DIV_FASTPATH_EN
        state_next = (in_div0 || in_ovf || (op2 == {{(WIDTH-1){1'b0}}, 1'b1}))
                     ? MDU_ST_FIX : MDU_ST_RUN;
`else
        state_next = MDU_ST_RUN;
`endif
      end
      MDU_ST_RUN: begin
        if (flush)                              state_next = MDU_ST_IDLE;
        else if (cnt_reg == CW'(WIDTH - 1))     state_next = MDU_ST_FIX;
      end
      MDU_ST_FIX:  state_next = flush ? MDU_ST_IDLE : MDU_ST_DONE;
      MDU_ST_DONE: state_next = MDU_ST_IDLE;
      default:     state_next = MDU_ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != MDU_ST_IDLE);
    done = (state_reg == MDU_ST_DONE);
  end

  // Special cases override whatever the iterations produced.
  always_comb begin
    q_fix = q_neg_reg ? (~quo_reg + 1'b1) : quo_reg;
    r_fix = r_neg_reg ? (~rem_reg[WIDTH-1:0] + 1'b1) : rem_reg[WIDTH-1:0];
    if (div0_reg)     fix_value = op_is_rem(op_reg) ? op1_reg : '1;
    else if (ovf_reg) fix_value = op_is_rem(op_reg) ? '0 : MIN_VAL;
    else              fix_value = op_is_rem(op_reg) ? r_fix : q_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg      <= '0;
      op1_reg     <= '0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      cnt_reg     <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      div0_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      result_reg  <= '0;
    end else begin
      if (start_accept) begin
        op_reg      <= div_op;
        op1_reg     <= op1;
        divisor_reg <= abs2;
        rem_reg     <= '0;
        quo_reg     <= abs1;
        cnt_reg     <= '0;
        q_neg_reg   <= a_neg ^ b_neg;
        r_neg_reg   <= a_neg;
        div0_reg    <= in_div0;
        ovf_reg     <= in_ovf;
      end else if (state_reg == MDU_ST_RUN) begin
        rem_reg <= rem_step;
        quo_reg <= quo_step;
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == MDU_ST_FIX && !flush)
        result_reg <= fix_value;
    end
  end

  assign result = result_reg;

endmodule
